ram_arbiter_2p: RTL

RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 14 +
 rtl/ram_arbiter_2p.sv | 103 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared defaults and FSM state type for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick. prio = 0 favours requester 0 and prio = 1
// favours requester 1 when both request. A lone requester always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic win0,
  output logic win1
);

  assign win0 = req0 & (~req1 | ~prio);
  assign win1 = req1 & (~req0 |  prio);

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two requesters sharing one single-port word array. An access takes an
// IDLE cycle (arbitrate + latch) and an ACCESS cycle (array op), so the
// sustained rate is one access every two cycles.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  arb_state_t        state;
  logic              prio;
  logic              win0, win1;
  logic              cmd_we;
  logic              cmd_owner;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  rr_arb2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .prio (prio),
    .win0 (win0),
    .win1 (win1)
  );

  // Control FSM: arbitrate and latch in IDLE, complete the access in ACCESS.
  // A reset during ACCESS forces IDLE, so no write or rvalid can follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      prio      <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_owner <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win0 | win1) begin
            cmd_owner <= win1;
            cmd_we    <= win1 ? we1    : we0;
            cmd_addr  <= win1 ? addr1  : addr0;
            cmd_wdata <= win1 ? wdata1 : wdata0;
            gnt0      <= win0;
            gnt1      <= win1;
            // point at the loser so contention alternates
            prio      <= win0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (!cmd_we) begin
            rdata   <= mem[cmd_addr];
            rvalid0 <= ~cmd_owner;
            rvalid1 <= cmd_owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == ACCESS && cmd_we)
      mem[cmd_addr] <= cmd_wdata;
  end

endmodule
